// File: rtl/tt_pkg.sv
// Shared widths, FSM state type and Chow-parameter container for the
// truth-table sweep/capture block.
package tt_pkg;

  localparam int N_IN   = 7;
  localparam int TT_W   = 1 << N_IN;
  localparam int CHOW_W = 7;
  localparam int ONES_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN,
    S_HOLD
  } tt_state_t;

  typedef logic [N_IN-1:0][CHOW_W-1:0] chow_t;

  // Field i lands in bits [7i+6:7i] of the flat output bus.
  function automatic logic [N_IN*CHOW_W-1:0] pack_chow(input chow_t c);
    logic [N_IN*CHOW_W-1:0] v;
    v = '0;
    for (int i = 0; i < N_IN; i++) begin
      v[i*CHOW_W +: CHOW_W] = c[i];
    end
    return v;
  endfunction

endpackage

// File: rtl/tt_capture_pipe.sv
// Delays {valid, idx} by LAT cycles so each FUT output bit is paired with the
// vector that produced it; LAT=0 is a straight wire.
module tt_capture_pipe #(
  parameter int LAT  = 0,
  parameter int N_IN = 7
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [N_IN-1:0] i_idx,
  output logic            o_valid,
  output logic [N_IN-1:0] o_idx
);

  generate
    if (LAT == 0) begin : g_bypass
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = i_clk ^ i_rst;
      assign o_valid = i_valid;
      assign o_idx   = i_idx;
    end else begin : g_pipe
      logic [LAT-1:0]  r_valid;
      logic [N_IN-1:0] r_idx [LAT];

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_valid <= '0;
        end else begin
          r_valid[0] <= i_valid;
          for (int i = 1; i < LAT; i++) begin
            r_valid[i] <= r_valid[i-1];
          end
        end
      end

      // NOTE: idx is only ever consumed when its valid flag is set, so the
      // index storage carries no reset; flushing the valid bits is enough.
      always_ff @(posedge i_clk) begin
        r_idx[0] <= i_idx;
        for (int i = 1; i < LAT; i++) begin
          r_idx[i] <= r_idx[i-1];
        end
      end

      assign o_valid = r_valid[LAT-1];
      assign o_idx   = r_idx[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps all 2^N_IN input vectors through an external FUT, captures its truth
// table plus Chow parameters, and offers the result on a valid/ready port.
module tt_sweep_capture #(
  parameter int N_IN = 7,
  parameter int LAT  = 0
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_start,
  output logic                              o_busy,
  output logic [N_IN-1:0]                   o_x,
  input  logic                              i_f_in,
  output logic [(1<<N_IN)-1:0]              o_tt,
  output logic [tt_pkg::ONES_W-1:0]         o_ones,
  output logic [N_IN*tt_pkg::CHOW_W-1:0]    o_chow,
  output logic                              o_tt_valid,
  input  logic                              i_tt_ready
);
  import tt_pkg::*;

  localparam logic [N_IN-1:0] X_LAST     = '1;
  localparam logic [1:0]      DRAIN_LAST = 2'(LAT > 0 ? LAT - 1 : 0);

  tt_state_t         r_state;
  tt_state_t         w_next_state;
  logic [N_IN-1:0]   r_x;
  logic [1:0]        r_drain_cnt;
  logic              r_busy;
  logic              r_tt_valid;
  logic [TT_W-1:0]   r_tt;
  logic [ONES_W-1:0] r_ones;
  chow_t             r_chow;

  logic              w_start_acc;
  logic              w_cap_valid;
  logic [N_IN-1:0]   w_cap_idx;

  assign w_start_acc = (r_state == S_IDLE) && i_start;

  always_comb begin
    // NOTE: every output of this block gets its default before the case, so
    // no path can leave it unassigned and infer a latch.
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start)          w_next_state = S_SWEEP;
      S_SWEEP: if (r_x == X_LAST)    w_next_state = (LAT > 0) ? S_DRAIN : S_HOLD;
      S_DRAIN: if (r_drain_cnt == '0) w_next_state = S_HOLD;
      S_HOLD:  if (i_tt_ready)       w_next_state = S_IDLE;
      default:                       w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_drain_cnt <= '0;
      r_busy      <= 1'b0;
      r_tt_valid  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates let every register see the pre-edge value
      // of the others, which is what the next-state logic assumed.
      r_state    <= w_next_state;
      r_busy     <= (w_next_state == S_SWEEP) || (w_next_state == S_DRAIN);
      r_tt_valid <= (w_next_state == S_HOLD);

      // The last increment wraps 127 -> 0, so x reads 0 outside the sweep.
      if (r_state == S_SWEEP) r_x <= r_x + N_IN'(1);
      else                    r_x <= '0;

      if (r_state == S_SWEEP)      r_drain_cnt <= DRAIN_LAST;
      else if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt - 2'd1;
    end
  end

  tt_capture_pipe #(
    .LAT  (LAT),
    .N_IN (N_IN)
  ) u_pipe (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (r_state == S_SWEEP),
    .i_idx   (r_x),
    .o_valid (w_cap_valid),
    .o_idx   (w_cap_idx)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tt   <= '0;
      r_ones <= '0;
      r_chow <= '0;
    end else if (w_start_acc) begin
      r_tt   <= '0;
      r_ones <= '0;
      r_chow <= '0;
    end else if (w_cap_valid) begin
      r_tt[w_cap_idx] <= i_f_in;
      if (i_f_in) begin
        r_ones <= r_ones + ONES_W'(1);
        for (int i = 0; i < N_IN; i++) begin
          if (w_cap_idx[i]) r_chow[i] <= r_chow[i] + CHOW_W'(1);
        end
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_x        = r_x;
  assign o_tt       = r_tt;
  assign o_ones     = r_ones;
  assign o_chow     = pack_chow(r_chow);
  assign o_tt_valid = r_tt_valid;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Runs a LAT=0 and a LAT=2 instance in lockstep against FUT truth tables and
// compares results with a counting model of the truth table and Chow sums.
module tb_tt_sweep_capture;

  logic         clk    = 1'b0;
  logic         rst    = 1'b1;
  logic         start  = 1'b0;
  logic         ready  = 1'b0;
  logic [127:0] fut_tt = '0;

  logic         busy0, valid0, f0;
  logic [6:0]   x0;
  logic [127:0] tt0;
  logic [7:0]   ones0;
  logic [48:0]  chow0;

  logic         busy2, valid2, f2;
  logic [6:0]   x2;
  logic [127:0] tt2;
  logic [7:0]   ones2;
  logic [48:0]  chow2;

  logic d1 = 1'b0;
  logic d2 = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign f0 = fut_tt[x0];
  always @(posedge clk) begin
    d1 <= fut_tt[x2];
    d2 <= d1;
  end
  assign f2 = d2;

  tt_sweep_capture #(.N_IN(7), .LAT(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy0), .o_x(x0),
    .i_f_in(f0), .o_tt(tt0), .o_ones(ones0), .o_chow(chow0),
    .o_tt_valid(valid0), .i_tt_ready(ready)
  );

  tt_sweep_capture #(.N_IN(7), .LAT(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy2), .o_x(x2),
    .i_f_in(f2), .o_tt(tt2), .o_ones(ones2), .o_chow(chow2),
    .o_tt_valid(valid2), .i_tt_ready(ready)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ref_ones(input logic [127:0] t);
    int c;
    c = 0;
    for (int k = 0; k < 128; k++) if (t[k]) c++;
    return 128'(c);
  endfunction

  function automatic logic [127:0] ref_chow(input logic [127:0] t);
    logic [48:0] v;
    int c;
    v = '0;
    for (int i = 0; i < 7; i++) begin
      c = 0;
      for (int k = 0; k < 128; k++) if (t[k] && (((k >> i) & 1) == 1)) c++;
      v[7*i +: 7] = 7'(c);
    end
    return {79'b0, v};
  endfunction

  function automatic logic [127:0] rand_tt();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_result(input string tag, input logic [127:0] t,
                              input logic [127:0] tt, input logic [7:0] ones,
                              input logic [48:0] chow);
    check({tag, "_tt"},   tt,   t);
    check({tag, "_ones"}, {120'b0, ones}, ref_ones(t));
    check({tag, "_chow"}, {79'b0, chow},  ref_chow(t));
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full sweep with ready held high; loop index n is the edge count since E0.
  task automatic do_sweep(input logic [127:0] t, input string name, input int pulse_at);
    int rise0, rise2, fall0, fall2, w0, w2, xbad0, xbad2;
    logic [127:0] ctt0, ctt2;
    logic [7:0]   co0, co2;
    logic [48:0]  cc0, cc2;
    rise0 = -1; rise2 = -1; fall0 = -1; fall2 = -1;
    w0 = 0; w2 = 0; xbad0 = 0; xbad2 = 0;
    ctt0 = '0; ctt2 = '0; co0 = '0; co2 = '0; cc0 = '0; cc2 = '0;
    fut_tt = t;
    ready  = 1'b1;
    launch();
    for (int n = 0; n < 140; n++) begin
      start = (n == pulse_at);
      if (valid0) begin
        if (rise0 < 0) begin rise0 = n; ctt0 = tt0; co0 = ones0; cc0 = chow0; end
        w0++;
      end
      if (valid2) begin
        if (rise2 < 0) begin rise2 = n; ctt2 = tt2; co2 = ones2; cc2 = chow2; end
        w2++;
      end
      if (!busy0 && fall0 < 0) fall0 = n;
      if (!busy2 && fall2 < 0) fall2 = n;
      if (n <= 128 && x0 !== 7'((n < 128) ? n : 0)) xbad0++;
      if (n <= 129 && x2 !== 7'((n < 128) ? n : 0)) xbad2++;
      @(negedge clk);
    end
    start = 1'b0;
    check({name, "_rise_lat0"},  128'(rise0), 128'(128));
    check({name, "_rise_lat2"},  128'(rise2), 128'(130));
    check({name, "_width_lat0"}, 128'(w0),    128'(1));
    check({name, "_width_lat2"}, 128'(w2),    128'(1));
    check({name, "_busy_lat0"},  128'(fall0), 128'(128));
    check({name, "_busy_lat2"},  128'(fall2), 128'(130));
    check({name, "_x_lat0"},     128'(xbad0), 128'(0));
    check({name, "_x_lat2"},     128'(xbad2), 128'(0));
    check_result({name, "_lat0"}, t, ctt0, co0, cc0);
    check_result({name, "_lat2"}, t, ctt2, co2, cc2);
  endtask

  task automatic backpressure(input logic [127:0] t);
    int n, unstable, idle_bad;
    fut_tt = t;
    ready  = 1'b0;
    launch();
    n = 0;
    while (!(valid0 && valid2) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp_reach_hold", {127'b0, valid0 && valid2}, 128'(1));
    unstable = 0;
    for (int c = 0; c < 20; c++) begin
      start = (c == 10);
      if (!valid0 || !valid2 || busy0 || busy2 || tt0 !== t || tt2 !== t) unstable++;
      @(negedge clk);
    end
    check("bp_stable", 128'(unstable), 128'(0));
    start = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("bp_accept", {126'b0, valid0, valid2}, 128'(0));
    idle_bad = 0;
    for (int c = 0; c < 6; c++) begin
      if (busy0 || busy2 || valid0 || valid2 || x0 !== '0 || x2 !== '0) idle_bad++;
      @(negedge clk);
    end
    check("bp_no_second_sweep", 128'(idle_bad), 128'(0));
    check_result("bp_kept_lat0", t, tt0, ones0, chow0);
    check_result("bp_kept_lat2", t, tt2, ones2, chow2);
  endtask

  task automatic reset_mid_sweep();
    int n;
    fut_tt = rand_tt();
    ready  = 1'b1;
    launch();
    n = 0;
    while (x0 != 7'd60 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_x60", {121'b0, x0}, 128'(60));
    rst = 1'b1;
    #1;
    check("rst_mid_ctl_lat0", {62'b0, busy0, valid0, x0, ones0, chow0}, 128'(0));
    check("rst_mid_tt_lat0",  tt0, 128'(0));
    check("rst_mid_ctl_lat2", {62'b0, busy2, valid2, x2, ones2, chow2}, 128'(0));
    check("rst_mid_tt_lat2",  tt2, 128'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] t;

    repeat (3) @(negedge clk);
    check("reset_lat0", {62'b0, busy0, valid0, x0, ones0, chow0}, 128'(0));
    check("reset_tt_lat0", tt0, 128'(0));
    check("reset_lat2", {62'b0, busy2, valid2, x2, ones2, chow2}, 128'(0));
    check("reset_tt_lat2", tt2, 128'(0));
    rst = 1'b0;
    @(negedge clk);

    t = '0;
    t[127] = 1'b1;
    do_sweep(t, "and7", -1);

    for (int k = 0; k < 128; k++) t[k] = ((k & 1) == 1);
    do_sweep(t, "proj_x0", -1);

    for (int k = 0; k < 128; k++) t[k] = ($countones(7'(k)) >= 4);
    do_sweep(t, "maj7", -1);

    do_sweep(128'(0), "const0", -1);

    do_sweep(rand_tt(), "rand_a", 50);
    do_sweep(rand_tt(), "rand_b", 100);

    backpressure(rand_tt());

    reset_mid_sweep();
    do_sweep(rand_tt(), "after_rst", 40);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tt_sweep_capture.md
# tt_sweep_capture

Sequencer and capture stage wrapped around a 7-input combinational function-under-test (FUT) in the classification flow. On `start` it drives all 128 input vectors onto `x`, samples the FUT's single-bit output and assembles the 128-bit truth table. Alongside the table it computes Chow parameters: the total ones count and the per-variable positive-cofactor ones counts. It then presents the result on a valid/ready port to the downstream classifier.

## Interface
- `N_IN`, 7, function arity; fixed at 7, because the width rules below depend on it.
- `LAT`, 0, FUT latency in cycles; 0 means combinational, legal range 0..3.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  sweep request; sampled only in IDLE.
- `busy`  out  1  high in SWEEP and DRAIN.
- `x`  out  7  vector to the FUT; `x[0]` is the LSB of the index.
- `f_in`  in  1  FUT output.
- `tt`  out  128  truth table; `tt[k] = f(x=k)`. Printed as hex, MSB first.
- `ones`  out  8  popcount of `tt`, range 0..128.
- `chow`  out  49  seven 7-bit fields; field i is `chow[7i+6:7i]` and holds the count of k with `tt[k]=1` and `k[i]=1`, range 0..64.
- `tt_valid`  out  1  result available.
- `tt_ready`  in  1  downstream accepts the result.

## Operation
- **Reset values:** every output is 0 (`busy`, `x`, `tt`, `ones`, `chow`, `tt_valid`).
- **States:** IDLE, SWEEP, DRAIN, HOLD.
- **IDLE:** `start=1` moves to SWEEP. On the same edge, `tt`, `ones` and `chow` clear to 0, and `x` becomes 0.
- **SWEEP:** `x` increments by 1 per cycle from 0 to 127.
  - At `x=127`, go to DRAIN if `LAT>0`, otherwise go to HOLD.
  - The `x` register must not wrap visibly: after the sweep, `x` returns to 0.
- **DRAIN:** lasts exactly `LAT` cycles, with `x=0`. It only finishes capture of the bits still in flight.
- **Capture:** a `LAT`-deep pipe carries a valid flag and the 7-bit index alongside each presented vector. On each captured bit:
  - `tt[idx] <= f_in`.
  - If `f_in=1`: `ones += 1`, and for each i with `idx[i]=1`, `chow_i += 1`.
  - All counters are saturation-free by construction (max 128 / 64). Width overflow is a design error.
- **HOLD:** `tt_valid=1` and the result is stable. When `tt_valid & tt_ready`, go to IDLE and clear `tt_valid`. `tt`, `ones` and `chow` keep their values until the next start.
- **`start` outside IDLE:** ignored, with no queuing. This includes HOLD and the accept cycle.
- **`tt_ready` outside HOLD:** ignored.
- **`rst` mid-sweep or in HOLD:** immediate return to IDLE. All outputs go to 0 and the capture pipe is flushed.

## Timing
- Call the edge where `start` is accepted E0.
- `x=k` is driven from edge Ek until edge Ek+1.
- `f_in` for vector k is sampled at edge E(k+1+LAT).
- `busy` is high from E0 to E(128+LAT).
- `tt_valid` rises at E(128+LAT). The sweep latency is therefore 128+LAT cycles.
- With `tt_ready` held high, `tt_valid` stays high for exactly 1 cycle. A new start can be accepted at the earliest 1 cycle after `tt_valid` falls.
- No combinational path from any input to any output.

## Structure
- Shared package `tt_pkg`:
  - `N_IN=7`, `TT_W=128`, `CHOW_W=7`, `ONES_W=8`;
  - the state enum `tt_state_t`;
  - the typedef `chow_t`, an array of 7 × 7-bit fields, and a function packing it to 49 bits.
- One sub-module, `tt_capture_pipe`: the `LAT`-deep shift of {valid, idx}, with the `LAT=0` bypass.
- The FSM, counters and truth-table register live in the top.

## Test plan
- **Combinational AND:** `LAT=0`, FUT = AND of all seven inputs.
  - `tt = 1<<127`, `ones=1`, every chow field = 1.
  - `tt_valid` rises exactly 128 cycles after start.
- **Projection:** `LAT=2`, FUT = x0 registered twice.
  - `tt = 0xAAAA…AAAA`, `ones=64`, `chow0=64`, chow1..6 = 32.
  - `tt_valid` rises at cycle 130.
- **Majority-of-7:** `ones=64`, every chow field = 42.
  - Then a constant-0 FUT: `tt=0`, `ones=0`, all chow = 0.
- **Backpressure:**
  - Hold `tt_ready=0` for 20 cycles: `tt_valid` stays high and the result is stable.
  - Pulse `start` during HOLD: ignored, no second sweep.
  - Raise `tt_ready`: IDLE on the next edge.
- **Reset and start mid-sweep:**
  - Assert `rst` at `x=60`: all outputs are 0 at once, state is IDLE.
  - A new start then yields a correct full table.
  - `start` pulsed during SWEEP has no effect on `x` or on the results.
